// File: rtl/inv_sub_bytes_ctrl.sv
// inv_sub_bytes_ctrl: sequenced AES InvSubBytes over NUM_SBOX shared inverse S-boxes
// Optional input bypass port when INV_SUB_BYTES_BYPASS_EN is defined.
module inv_sub_bytes_ctrl #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef INV_SUB_BYTES_BYPASS_EN
  input  logic         bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int STEPS = 16 / NUM_SBOX;
  localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;
  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 && NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_chk
    $error("inv_sub_bytes_ctrl: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;
  st_t st;
  logic [SW-1:0] step;
  logic [0:15][7:0] w, wn;
  logic [3:0] k;
`ifdef INV_SUB_BYTES_BYPASS_EN
  logic byp;
`endif
  // Entry 0x00 sits in the top byte, so byte x ends at bit 2047-8x = {~x,3'b111}.
  function automatic logic [7:0] isb(input logic [7:0] x);
    return ISBOX[{~x, 3'b111} -: 8];
  endfunction
  assign in_ready = st == IDLE;
  assign busy = st != IDLE;
  assign out_state = w;
  always_comb begin
    wn = w;
    k = '0;
    for (int j = 0; j < NUM_SBOX; j++) begin
      k = 4'(int'(step) * NUM_SBOX + j);
`ifdef INV_SUB_BYTES_BYPASS_EN
      wn[k] = byp ? w[k] : isb(w[k]);
`else
      wn[k] = isb(w[k]);
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      step <= '0;
      w <= '0;
      out_valid <= 1'b0;
`ifdef INV_SUB_BYTES_BYPASS_EN
      byp <= 1'b0;
`endif
    end else
      case (st)
        IDLE: if (in_valid) begin
          w <= in_state;
          step <= '0;
          st <= BUSY;
`ifdef INV_SUB_BYTES_BYPASS_EN
          byp <= bypass;
`endif
        end
        BUSY: begin
          w <= wn;
          step <= step + 1'b1;
          if (step == SW'(STEPS - 1)) begin
            st <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          st <= IDLE;
          out_valid <= 1'b0;
        end
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_inv_sub_bytes_ctrl.sv
// tb_inv_sub_bytes_ctrl: scoreboard bench for NUM_SBOX = 4, 1 and 16
// Reference inverse S-box is derived from GF(2^8) inversion and the AES affine map.
module tb_inv_sub_bytes_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] isb_ref [256];
  typedef struct {logic [127:0] d; int acc;} exp_t;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction
  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      isb_ref[s] = 8'(a);
    end
  end
  function automatic logic [127:0] model(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = isb_ref[x[127-8*i -: 8]];
    return y;
  endfunction
  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask
  task automatic chki(input string n, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask
  localparam logic [127:0] SEQ = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_INV = 128'h52096ad53036a538bf40a39e81f3d7fb;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int NS = g == 0 ? 4 : g == 1 ? 1 : 16;
    localparam int ST = 16 / NS;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;
`ifdef INV_SUB_BYTES_BYPASS_EN
    logic bypass;
`endif
    int cyc = 0;
    bit done = 1'b0;
    logic ov_prev = 1'b0;
    exp_t q[$];
    inv_sub_bytes_ctrl #(.NUM_SBOX(NS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
`ifdef INV_SUB_BYTES_BYPASS_EN
      .bypass(bypass),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
    );
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
      if (!rst_n) begin
        q.delete();
        ov_prev <= 1'b0;
      end else begin
        if (out_valid && !ov_prev) begin
          chki($sformatf("ns%0d_pending", NS), int'(q.size() > 0), 1);
          if (q.size() > 0) chki($sformatf("ns%0d_latency", NS), cyc - q[0].acc, ST);
        end
        if (out_valid && q.size() > 0) begin
          chk($sformatf("ns%0d_data", NS), out_state, q[0].d);
          chki($sformatf("ns%0d_in_ready_done", NS), int'(in_ready), 0);
          chki($sformatf("ns%0d_busy_done", NS), int'(busy), 1);
          if (out_ready) void'(q.pop_front());
        end
        ov_prev <= out_valid;
      end
    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit hold, output int acc);
      int t = 0;
      in_valid = 1'b1;
      in_state = d;
      acc = cyc;
      while (!in_ready && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (!in_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL ns%0d_accept_timeout: in_ready got 0, expected 1", NS);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      q.push_back('{e, cyc});
      in_valid = hold;
      if (!hold) in_state = rnd();
    endtask
    task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 300) begin
        @(posedge clk);
        t++;
      end
      #1;
      chki($sformatf("ns%0d_drain", NS), q.size(), 0);
    endtask
    initial begin
      int a, p;
      logic [127:0] r;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_state = '0;
`ifdef INV_SUB_BYTES_BYPASS_EN
      bypass = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chki($sformatf("ns%0d_rst_out_valid", NS), int'(out_valid), 0);
      chki($sformatf("ns%0d_rst_in_ready", NS), int'(in_ready), 1);
      chki($sformatf("ns%0d_rst_busy", NS), int'(busy), 0);
      chk($sformatf("ns%0d_rst_out_state", NS), out_state, '0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(SEQ, SEQ_INV, 1'b0, a);
      drain();
      send({16{8'h63}}, '0, 1'b0, a);
      drain();
      send({16{8'hff}}, {16{8'h7d}}, 1'b0, a);
      drain();
      // Reset right after the accept edge, while the block is still in BUSY
      r = rnd();
      send(r, model(r), 1'b0, a);
      rst_n = 1'b0;
      #1;
      chki($sformatf("ns%0d_mid_rst_out_valid", NS), int'(out_valid), 0);
      chki($sformatf("ns%0d_mid_rst_in_ready", NS), int'(in_ready), 1);
      chki($sformatf("ns%0d_mid_rst_busy", NS), int'(busy), 0);
      chk($sformatf("ns%0d_mid_rst_out_state", NS), out_state, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      r = rnd();
      send(r, model(r), 1'b0, a);
      drain();
      out_ready = 1'b0;
      r = rnd();
      send(r, model(r), 1'b0, a);
      for (int t = 0; t < 100 && !out_valid; t++) begin
        @(posedge clk);
        #1;
      end
      chki($sformatf("ns%0d_bp_reach_done", NS), int'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        in_valid = ~in_valid;
        in_state = rnd();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chki($sformatf("ns%0d_bp_idle", NS), int'(in_ready), 1);
      chki($sformatf("ns%0d_bp_out_valid", NS), int'(out_valid), 0);
      // IDLE, STEPS BUSY edges and one DONE edge separate consecutive accepts
      p = 0;
      for (int i = 0; i < 4; i++) begin
        r = rnd();
        send(r, model(r), i != 3, a);
        if (i > 0) chki($sformatf("ns%0d_b2b_spacing", NS), a - p, ST + 2);
        p = a;
      end
      drain();
      for (int i = 0; i < 12; i++) begin
        r = rnd();
        out_ready = 1'($urandom_range(0, 1));
        send(r, model(r), 1'b0, a);
        repeat ($urandom_range(0, ST + 3)) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
      end
`ifdef INV_SUB_BYTES_BYPASS_EN
      bypass = 1'b1;
      send(SEQ, SEQ, 1'b0, a);
      bypass = 1'b0;
      drain();
      send(SEQ, SEQ_INV, 1'b0, a);
      drain();
`endif
      done = 1'b1;
    end
  end
  initial begin
    int t = 0;
    while (!(u[0].done && u[1].done && u[2].done) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (!(u[0].done && u[1].done && u[2].done)) begin
      n_tests++;
      n_fail++;
      $display("FAIL global_timeout: drivers got unfinished, expected finished");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
